output_display_unit: RTL

Receiving end of the processor's OUT path. When the processing unit asserts OutWrite, this block captures the 16-bit output value. It converts the value to BCD with a sequential shift-add-3 (double-dabble) engine and drives the four active-low 7-segment displays, Display4 (most significant) through Display1. It replaces purely combinational output decoding so the multi-digit conversion costs no datapath timing.

---
 rtl/output_display_unit.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/output_display_unit.sv
// OUT-port display driver: captures a 16-bit value, converts it to BCD with a
// sequential double-dabble engine and drives four active-low 7-segment digits.
// Optional build macro: OUTDISP_SIGNED_EN (two's-complement input with minus sign).
module output_display_unit (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        OutWrite,
    input  logic [15:0] OutData,
    output logic        Busy,
    output logic [6:0]  Display4,
    output logic [6:0]  Display3,
    output logic [6:0]  Display2,
    output logic [6:0]  Display1
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_LOAD    = 2'd2
    } state_t;

    localparam logic [6:0] SEG_ZERO  = 7'b1000000;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_MINUS = 7'b0111111;

    state_t      r_state;
    state_t      w_next_state;
    logic        w_start;
    logic        r_busy;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [3:0]  r_step;
    logic        r_neg;
    logic        r_pend_valid;
    logic [15:0] r_pend_data;
    logic [6:0]  r_disp4, r_disp3, r_disp2, r_disp1;
    logic [15:0] w_cap_data;
    logic [15:0] w_cap_mag;
    logic        w_cap_neg;
    logic [18:0] w_bcd_adj;
    logic        w_ovf;
    logic [6:0]  w_seg4, w_seg3, w_seg2, w_seg1;

    function automatic logic [6:0] seg7(input logic [3:0] digit);
        case (digit)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b0000110;
        endcase
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] digit);
        add3 = (digit >= 4'd5) ? (digit + 4'd3) : digit;
    endfunction

    // A new conversion takes a pending value in LOAD unless a fresh write arrives on that edge
    always_comb begin
        if ((r_state == S_LOAD) && !OutWrite) begin
            w_cap_data = r_pend_data;
        end else begin
            w_cap_data = OutData;
        end
`ifdef OUTDISP_SIGNED_EN
        w_cap_neg = w_cap_data[15];
        if (w_cap_data[15]) begin
            w_cap_mag = 16'(17'd0 - {w_cap_data[15], w_cap_data});
        end else begin
            w_cap_mag = w_cap_data;
        end
`else
        w_cap_neg = 1'b0;
        w_cap_mag = w_cap_data;
`endif
    end

    // Top digit stays below 5 until after the final shift, so it is never adjusted
    always_comb begin
        w_bcd_adj = {r_bcd[18:16], add3(r_bcd[15:12]), add3(r_bcd[11:8]),
                     add3(r_bcd[7:4]), add3(r_bcd[3:0])};
    end

    // Next-state logic and conversion start decision
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (OutWrite) begin
                    w_start      = 1'b1;
                    w_next_state = S_CONVERT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_CONVERT: begin
                if (r_step == 4'd15) begin
                    w_next_state = S_LOAD;
                end else begin
                    w_next_state = S_CONVERT;
                end
            end
            S_LOAD: begin
                if (OutWrite || r_pend_valid) begin
                    w_start      = 1'b1;
                    w_next_state = S_CONVERT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Segment patterns for the finished conversion result
    always_comb begin
        if (r_neg) begin
            w_ovf = (r_bcd[19:12] != 8'd0);
        end else begin
            w_ovf = (r_bcd[19:16] != 4'd0);
        end
        if (w_ovf) begin
            w_seg4 = SEG_E;
            w_seg3 = SEG_E;
            w_seg2 = SEG_E;
            w_seg1 = SEG_E;
        end else if (r_neg) begin
            w_seg4 = SEG_MINUS;
            w_seg3 = seg7(r_bcd[11:8]);
            w_seg2 = seg7(r_bcd[7:4]);
            w_seg1 = seg7(r_bcd[3:0]);
        end else begin
            w_seg4 = seg7(r_bcd[15:12]);
            w_seg3 = seg7(r_bcd[11:8]);
            w_seg2 = seg7(r_bcd[7:4]);
            w_seg1 = seg7(r_bcd[3:0]);
        end
    end

    // State, conversion datapath, pending slot and display registers
    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_busy       <= 1'b0;
            r_bin        <= 16'd0;
            r_bcd        <= 20'd0;
            r_step       <= 4'd0;
            r_neg        <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_data  <= 16'd0;
            r_disp4      <= SEG_ZERO;
            r_disp3      <= SEG_ZERO;
            r_disp2      <= SEG_ZERO;
            r_disp1      <= SEG_ZERO;
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state != S_IDLE);
            if (w_start) begin
                r_bin  <= w_cap_mag;
                r_neg  <= w_cap_neg;
                r_bcd  <= 20'd0;
                r_step <= 4'd0;
            end else if (r_state == S_CONVERT) begin
                r_bcd  <= {w_bcd_adj, r_bin[15]};
                r_bin  <= {r_bin[14:0], 1'b0};
                r_step <= r_step + 4'd1;
            end
            if ((r_state == S_CONVERT) && OutWrite) begin
                r_pend_valid <= 1'b1;
                r_pend_data  <= OutData;
            end else if (r_state == S_LOAD) begin
                r_pend_valid <= 1'b0;
            end
            if (r_state == S_LOAD) begin
                r_disp4 <= w_seg4;
                r_disp3 <= w_seg3;
                r_disp2 <= w_seg2;
                r_disp1 <= w_seg1;
            end
        end
    end

    assign Busy     = r_busy;
    assign Display4 = r_disp4;
    assign Display3 = r_disp3;
    assign Display2 = r_disp2;
    assign Display1 = r_disp1;

endmodule
